// File: rtl/dbus_sram_responder_if.sv
// Data-bus request/response types and the bus interface between the Memory stage and a responder.
// Initiator drives dreq; responder drives dresp.
package dbus_pkg;
    typedef enum logic [1:0] {
        MSIZE1 = 2'd0,
        MSIZE2 = 2'd1,
        MSIZE4 = 2'd2
    } msize_t;

    typedef struct packed {
        logic        valid;
        logic [31:0] addr;
        msize_t      size;
        logic [3:0]  strobe;
        logic [31:0] data;
    } dbus_req_t;

    typedef struct packed {
        logic        addr_ok;
        logic        data_ok;
        logic [31:0] data;
    } dbus_resp_t;
endpackage

interface dbus_sram_responder_if;
    import dbus_pkg::*;

    dbus_req_t  dreq;
    dbus_resp_t dresp;

    modport master (output dreq, input dresp);
    modport slave  (input dreq, output dresp);
endinterface

// File: rtl/dbus_sram_responder.sv
// Word SRAM data-bus responder with byte strobes, one outstanding transaction.
// Latency: addr_ok ADDR_LAT cycles after valid rises, data_ok DATA_LAT cycles after addr_ok.
// Backpressure: addr_ok withheld until latency elapses; DBUS_RAND_STALL_EN adds LFSR-driven stalls.
module dbus_sram_responder
    import dbus_pkg::*;
#(
    parameter int AW       = 10,
    parameter int ADDR_LAT = 0,
    parameter int DATA_LAT = 0
) (
    input  logic clk,
    input  logic reset,
    dbus_sram_responder_if.slave dbus
);

    localparam int MAXL = (ADDR_LAT > DATA_LAT) ? ADDR_LAT : DATA_LAT;
    localparam int CW   = (MAXL > 0) ? $clog2(MAXL + 1) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        AWAIT = 2'd1,
        DWAIT = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           accept;
    logic           stall;
    logic           rd_q;
    logic [31:0]    rd_word_q;
    logic [31:0]    mem [0:(1<<AW)-1];
    logic [AW-1:0]  idx;
    logic           is_rd;
    logic           unused_bits;

    assign idx         = dbus.dreq.addr[AW+1:2];
    assign is_rd       = (dbus.dreq.strobe == 4'b0000);
    assign unused_bits = ^{dbus.dreq.size, dbus.dreq.addr[31:AW+2], dbus.dreq.addr[1:0]};

`ifdef DBUS_RAND_STALL_EN
    logic [7:0] lfsr_q;

    // x^8+x^6+x^5+x^4+1, shifting left with feedback into bit 0
    always_ff @(posedge clk) begin
        if (reset) lfsr_q <= 8'hA5;
        else       lfsr_q <= {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    end
    assign stall = (lfsr_q[1:0] == 2'b00);
`else
    assign stall = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            rd_q      <= 1'b0;
            rd_word_q <= 32'h0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                rd_q      <= is_rd;
                rd_word_q <= mem[idx];
            end
        end
    end

    // Writes commit on the accept edge; a later reset cannot undo them.
    always_ff @(posedge clk) begin
        if (accept && !is_rd) begin
            for (int i = 0; i < 4; i++) begin
                if (dbus.dreq.strobe[i]) mem[idx][8*i +: 8] <= dbus.dreq.data[8*i +: 8];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        accept  = 1'b0;
        case (state_q)
            IDLE: begin
                if (dbus.dreq.valid) begin
                    if (ADDR_LAT == 0) begin
                        accept = !stall;
                    end else begin
                        state_d = AWAIT;
                        cnt_d   = CW'(1);
                    end
                end
            end
            AWAIT: begin
                if (!dbus.dreq.valid) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == CW'(ADDR_LAT)) begin
                    accept = !stall;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            DWAIT: begin
                if (cnt_q == CW'(DATA_LAT)) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
        if (accept) begin
            if (DATA_LAT == 0) begin
                state_d = IDLE;
                cnt_d   = '0;
            end else begin
                state_d = DWAIT;
                cnt_d   = CW'(1);
            end
        end
        if (reset) accept = 1'b0;
    end

    always_comb begin
        dbus.dresp = '0;
        if (!reset) begin
            if (accept) begin
                dbus.dresp.addr_ok = 1'b1;
                if (DATA_LAT == 0) begin
                    dbus.dresp.data_ok = 1'b1;
                    if (is_rd) dbus.dresp.data = mem[idx];
                end
            end else if (state_q == DWAIT && cnt_q == CW'(DATA_LAT)) begin
                dbus.dresp.data_ok = 1'b1;
                if (rd_q) dbus.dresp.data = rd_word_q;
            end
        end
    end

endmodule

// File: tb/tb_dbus_sram_responder.sv
// Directed bench: three responder instances covering zero latency, 2/3 latency and AW=4 with 3/4 latency.
module tb_dbus_sram_responder;
    import dbus_pkg::*;

    logic clk;
    logic reset;
    int   checks   = 0;
    int   failures = 0;

    dbus_sram_responder_if ifa ();
    dbus_sram_responder_if ifb ();
    dbus_sram_responder_if ifc ();

    dbus_sram_responder #(.AW(10), .ADDR_LAT(0), .DATA_LAT(0)) u_a (.clk(clk), .reset(reset), .dbus(ifa));
    dbus_sram_responder #(.AW(10), .ADDR_LAT(2), .DATA_LAT(3)) u_b (.clk(clk), .reset(reset), .dbus(ifb));
    dbus_sram_responder #(.AW(4),  .ADDR_LAT(3), .DATA_LAT(4)) u_c (.clk(clk), .reset(reset), .dbus(ifc));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic dbus_req_t mkreq(input logic v, input logic [31:0] a,
                                        input logic [3:0] s, input logic [31:0] d);
        dbus_req_t r;
        r.valid  = v;
        r.addr   = a;
        r.size   = MSIZE4;
        r.strobe = s;
        r.data   = d;
        return r;
    endfunction

    task automatic drive(input int which, input dbus_req_t r);
        case (which)
            0:       ifa.dreq = r;
            1:       ifb.dreq = r;
            default: ifc.dreq = r;
        endcase
    endtask

    function automatic logic [33:0] resp(input int which);
        case (which)
            0:       return ifa.dresp;
            1:       return ifb.dresp;
            default: return ifc.dresp;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [33:0] obs, input logic [33:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed={ao,do,data}=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Holds valid until the expected addr_ok cycle, checks every cycle through data_ok.
    task automatic txn(input int which, input int alat, input int dlat, input logic [31:0] addr,
                       input logic [3:0] strb, input logic [31:0] wd, input logic [31:0] exp_rd,
                       input string tag);
        logic [33:0] exp;
        for (int c = 0; c <= alat + dlat; c++) begin
            drive(which, mkreq(c <= alat, addr, strb, wd));
            #1;
            exp = {c == alat, c == alat + dlat, (c == alat + dlat) ? exp_rd : 32'h0};
            chk($sformatf("%s_c%0d", tag, c), resp(which), exp);
            tick();
        end
        drive(which, mkreq(1'b0, 32'h0, 4'h0, 32'h0));
    endtask

    initial begin
        logic [33:0] exp;
        reset = 1'b1;
        drive(0, mkreq(1'b1, 32'h100, 4'hF, 32'h12345678));
        drive(1, mkreq(1'b0, 32'h0, 4'h0, 32'h0));
        drive(2, mkreq(1'b0, 32'h0, 4'h0, 32'h0));
        tick();
        #1;
        chk("reset_a_forced0", resp(0), 34'h0);
        chk("reset_b", resp(1), 34'h0);
        chk("reset_c", resp(2), 34'h0);
        drive(0, mkreq(1'b0, 32'h0, 4'h0, 32'h0));
        tick();
        reset = 1'b0;
        tick();

        // Zero latency: write then read back, both handshakes in the request cycle.
        txn(0, 0, 0, 32'h100, 4'hF, 32'hDEADBEEF, 32'h0, "t1_wr");
        txn(0, 0, 0, 32'h100, 4'h0, 32'h0, 32'hDEADBEEF, "t1_rd");
        #1;
        chk("t1_idle", resp(0), 34'h0);
        tick();

        // Byte strobe merges only byte 2.
        txn(0, 0, 0, 32'h104, 4'hF, 32'h11223344, 32'h0, "t2_wr_full");
        txn(0, 0, 0, 32'h104, 4'b0100, 32'h00AA0000, 32'h0, "t2_wr_byte");
        txn(0, 0, 0, 32'h104, 4'h0, 32'h0, 32'h11AA3344, "t2_rd");

        // Latency 2/3 with valid held high across data_ok and into a second request.
        txn(1, 2, 3, 32'h300, 4'hF, 32'hCAFEF00D, 32'h0, "t3_wr");
        for (int c = 0; c <= 11; c++) begin
            drive(1, mkreq(c <= 8, 32'h300, 4'h0, 32'h0));
            #1;
            exp = {(c == 2 || c == 8), (c == 5 || c == 11),
                   (c == 5 || c == 11) ? 32'hCAFEF00D : 32'h0};
            chk($sformatf("t3_rd_c%0d", c), resp(1), exp);
            tick();
        end
        drive(1, mkreq(1'b0, 32'h0, 4'h0, 32'h0));

        // Withdrawal before acceptance leaves the SRAM untouched.
        txn(2, 3, 4, 32'h08, 4'hF, 32'h5A5A5A5A, 32'h0, "t4_wr");
        for (int c = 0; c <= 4; c++) begin
            drive(2, mkreq(c < 2, 32'h08, 4'hF, 32'hFFFFFFFF));
            #1;
            chk($sformatf("t4_wd_c%0d", c), resp(2), 34'h0);
            tick();
        end
        txn(2, 3, 4, 32'h08, 4'h0, 32'h0, 32'h5A5A5A5A, "t4_rd");

        // Reset while waiting for data_ok: no data_ok, but the accepted write sticks.
        for (int c = 0; c <= 9; c++) begin
            drive(2, mkreq(c <= 3, 32'h200, 4'hF, 32'h0BADC0DE));
            #1;
            chk($sformatf("t5_c%0d", c), resp(2), {c == 3, 1'b0, 32'h0});
            if (c == 5) reset = 1'b1;
            if (c == 6) reset = 1'b0;
            tick();
        end
        txn(2, 3, 4, 32'h200, 4'h0, 32'h0, 32'h0BADC0DE, "t5_rd");

        // AW=4 aliasing: 0x40, 0x0 and 0x200 all map to index 0.
        txn(2, 3, 4, 32'h40, 4'hF, 32'h13579BDF, 32'h0, "t6_wr");
        txn(2, 3, 4, 32'h0, 4'h0, 32'h0, 32'h13579BDF, "t6_rd");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
